// File: rtl/shake_stream_model_if.sv
`default_nettype none
// ============================================================================
// Module   : shake_stream_model_if
// Purpose  : Handshake/bus bundle between the FrodoKEM datapath and the
//            SHAKE stream model. Absorb-side beat handshake with request
//            parameters, squeeze-side block handshake with output memory
//            address, and status.
// Signals  : i_in_valid/o_in_ready/i_in_last   absorb beat handshake
//            i_out_size/i_rate_sel/i_base_addr/i_burst  request parameters
//            o_out_valid/i_out_ready            squeezed block handshake
//            o_mem_addr/o_mem_en                output memory access
//            o_busy/o_done/o_blk_cnt            status
// Modports : slave  = the SHAKE model, master = the datapath driving it
// Revision : 1.0  initial release
// ============================================================================
interface shake_stream_model_if #(
  parameter int ADDR_W = 7,
  parameter int SIZE_W = 32
);
  logic              i_in_valid;
  logic              o_in_ready;
  logic              i_in_last;
  logic [SIZE_W-1:0] i_out_size;
  logic              i_rate_sel;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_burst;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_en;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_blk_cnt;

  modport slave (
    input  i_in_valid, i_in_last, i_out_size, i_rate_sel, i_base_addr,
           i_burst, i_out_ready,
    output o_in_ready, o_out_valid, o_mem_addr, o_mem_en, o_busy, o_done,
           o_blk_cnt
  );

  modport master (
    output i_in_valid, i_in_last, i_out_size, i_rate_sel, i_base_addr,
           i_burst, i_out_ready,
    input  o_in_ready, o_out_valid, o_mem_addr, o_mem_en, o_busy, o_done,
           o_blk_cnt
  );
endinterface
`default_nettype wire

// File: rtl/shake_stream_model.sv
`default_nettype none
// ============================================================================
// Module   : shake_stream_model
// Purpose  : Cycle-accurate model of a SHAKE128/SHAKE256 core as seen from
//            the FrodoKEM datapath. Accepts multi-beat absorb requests,
//            spends LATENCY cycles per permutation, and emits squeezed
//            blocks as addresses into an external pre-loaded memory until
//            the requested number of output bits has been credited.
// Ports    : i_clk    clock
//            i_rst_n  asynchronous active-low reset
//            bus      shake_stream_model_if.slave (handshakes, params, status)
// Revision : 1.0  initial release
// ============================================================================
module shake_stream_model #(
  parameter int DATA_W  = 1344,
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 24,
  parameter int RATE128 = 1344,
  parameter int RATE256 = 1088,
  parameter int SIZE_W  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  shake_stream_model_if.slave   bus
);

  // A block on the memory bus must hold a whole rate's worth of bits, and the
  // latency counter is 8 bits wide.
  generate
    if (LATENCY < 1 || LATENCY > 255 || DATA_W < RATE128 || DATA_W < RATE256)
    begin : g_bad_params
      $error("shake_stream_model: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_APERM   = 3'd2,
    ST_SPERM   = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] c_LAT_LAST = 8'(LATENCY - 1);

  state_t            state_q,    state_d;
  logic [7:0]        lat_q,      lat_d;
  logic [SIZE_W-1:0] size_q,     size_d;
  logic              rate_q,     rate_d;
  logic              burst_q,    burst_d;
  logic [SIZE_W-1:0] bits_q,     bits_d;
  logic [15:0]       blk_q,      blk_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              in_ready_q, in_ready_d;

  logic [SIZE_W-1:0] w_rate_bits;
  logic [SIZE_W:0]   w_sum;
  logic [SIZE_W-1:0] w_bits_add;
  logic              w_lat_end;

  // Saturating bit credit: one extra bit catches the carry, which pins the
  // counter at all-ones instead of letting it wrap below the request size.
  assign w_rate_bits = rate_q ? SIZE_W'(RATE256) : SIZE_W'(RATE128);
  assign w_sum       = {1'b0, bits_q} + {1'b0, w_rate_bits};
  assign w_bits_add  = w_sum[SIZE_W] ? {SIZE_W{1'b1}} : w_sum[SIZE_W-1:0];
  assign w_lat_end   = (lat_q == c_LAT_LAST);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    size_d  = size_q;
    rate_d  = rate_q;
    burst_d = burst_q;
    bits_d  = bits_q;
    blk_d   = blk_q;
    addr_d  = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_in_valid) begin
          size_d  = bus.i_out_size;
          rate_d  = bus.i_rate_sel;
          burst_d = bus.i_burst;
          addr_d  = bus.i_base_addr;
          bits_d  = '0;
          blk_d   = '0;
          lat_d   = '0;
          state_d = bus.i_in_last ? ST_SPERM : ST_APERM;
        end
      end
      ST_APERM: begin
        if (w_lat_end) begin
          lat_d   = '0;
          state_d = ST_ABSORB;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      ST_ABSORB: begin
        if (bus.i_in_valid) begin
          lat_d   = '0;
          state_d = bus.i_in_last ? ST_SPERM : ST_APERM;
        end
      end
      ST_SPERM: begin
        // A zero-length request still pays one permutation, then finishes
        // without ever presenting a block.
        if (w_lat_end) begin
          lat_d   = '0;
          state_d = (size_q == '0) ? ST_DONE : ST_SQUEEZE;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      ST_SQUEEZE: begin
        if (bus.i_out_ready) begin
          bits_d = w_bits_add;
          blk_d  = blk_q + 16'd1;
          addr_d = addr_q + 1'b1;
          if (w_bits_add >= size_q) begin
            state_d = ST_DONE;
          end else if (!burst_q) begin
            state_d = ST_SPERM;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so the flag reads 0 while in reset.
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ABSORB);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      size_q     <= '0;
      rate_q     <= 1'b0;
      burst_q    <= 1'b0;
      bits_q     <= '0;
      blk_q      <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      size_q     <= size_d;
      rate_q     <= rate_d;
      burst_q    <= burst_d;
      bits_q     <= bits_d;
      blk_q      <= blk_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_out_valid = (state_q == ST_SQUEEZE);
  assign bus.o_mem_en    = (state_q == ST_SQUEEZE);
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_done      = (state_q == ST_DONE);
  assign bus.o_blk_cnt   = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_shake_stream_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_shake_stream_model
// Purpose  : Self-checking bench for shake_stream_model. A request driver
//            pushes the expected block sequence into a scoreboard queue; an
//            independent monitor pops and compares on every squeeze
//            handshake and checks block timing and completion.
// Revision : 1.0  initial release
// ============================================================================
module tb_shake_stream_model;
  localparam int ADDR_W  = 7;
  localparam int SIZE_W  = 32;
  localparam int LATENCY = 24;
  localparam int RATE128 = 1344;
  localparam int RATE256 = 1088;
  localparam int ADDR_N  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shake_stream_model_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

  shake_stream_model #(
    .DATA_W (1344),
    .ADDR_W (ADDR_W),
    .LATENCY(LATENCY),
    .RATE128(RATE128),
    .RATE256(RATE256),
    .SIZE_W (SIZE_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int idx;
  } blk_t;

  blk_t exp_q[$];
  int   due_cyc     = 0;
  int   done_due    = -1;
  int   exp_n       = 0;
  bit   blk_open    = 1'b0;
  bit   req_pending = 1'b0;
  bit   cur_burst   = 1'b0;
  int   rdy_mode    = 0;   // 0 = ready high, 1 = random, 2 = held low

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
  endtask

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Number of blocks a request needs: the bit count is credited a whole rate
  // per block and stops once it reaches the requested size.
  function automatic int blocks_for(input int unsigned size, input bit rate);
    longint r;
    r = rate ? RATE256 : RATE128;
    if (size == 0) return 0;
    return int'((longint'(size) + r - 1) / r);
  endfunction

  // Consumer ready driver
  initial begin
    bus.i_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.i_out_ready = 1'b1;
        1:       bus.i_out_ready = ($urandom_range(0, 3) != 0);
        default: bus.i_out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_out_valid) begin
          check("mem_en_with_valid", bus.o_mem_en, 1);
          if (exp_q.size() == 0) begin
            check("blocks_pending_at_valid", exp_q.size(), 1);
          end else begin
            if (!blk_open) begin
              check("valid_cycle", cyc, due_cyc);
              blk_open = 1'b1;
            end
            check("mem_addr", bus.o_mem_addr, exp_q[0].addr);
            if (bus.i_out_ready) begin
              check("blk_cnt_at_handshake", bus.o_blk_cnt, exp_q[0].idx);
              void'(exp_q.pop_front());
              blk_open = 1'b0;
              due_cyc  = cur_burst ? cyc + 1 : cyc + 1 + LATENCY;
              if (exp_q.size() == 0) done_due = cyc + 1;
            end
          end
        end else if (blk_open) begin
          check("valid_held_until_handshake", bus.o_out_valid, 1);
          blk_open = 1'b0;
        end
        if (bus.o_done) begin
          if (!req_pending) begin
            check("done_expected", req_pending, 1);
          end else begin
            check("done_cycle", cyc, done_due);
            check("done_blk_cnt", bus.o_blk_cnt, exp_n);
            check("done_blocks_left", exp_q.size(), 0);
            check("busy_in_done", bus.o_busy, 1);
            req_pending = 1'b0;
          end
        end
      end
    end
  end

  // Issues all absorb beats of one request and arms the scoreboard.
  task automatic start_req(input int unsigned size, input bit rate,
                           input int base, input bit burst, input int nbeats);
    int t;
    int prev_t;
    int budget;
    int n;
    n = blocks_for(size, rate);
    prev_t = 0;
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk);
      #1;
      bus.i_in_valid = 1'b1;
      bus.i_in_last  = (b == nbeats - 1);
      if (b == 0) begin
        bus.i_out_size  = size;
        bus.i_rate_sel  = rate;
        bus.i_base_addr = ADDR_W'(base);
        bus.i_burst     = burst;
      end else begin
        // Later beats carry junk parameters; they must not be resampled.
        bus.i_out_size  = $urandom;
        bus.i_rate_sel  = $urandom_range(0, 1);
        bus.i_base_addr = ADDR_W'($urandom);
        bus.i_burst     = $urandom_range(0, 1);
      end
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!bus.o_in_ready && budget < 300);
      if (!bus.o_in_ready) begin
        timeout_fail("in_ready_wait");
        summary_and_finish();
      end
      t = cyc;
      if (b > 0) check("absorb_ready_gap", t, prev_t + 1 + LATENCY);
      prev_t = t;
      if (b == nbeats - 1) begin
        exp_q.delete();
        for (int k = 0; k < n; k++)
          exp_q.push_back('{addr: (base + k) % ADDR_N, idx: k});
        exp_n       = n;
        cur_burst   = burst;
        blk_open    = 1'b0;
        due_cyc     = t + 1 + LATENCY;
        done_due    = (n == 0) ? t + 1 + LATENCY : -1;
        req_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.i_in_valid  = 1'b0;
    bus.i_in_last   = 1'b0;
    bus.i_out_size  = $urandom;
    bus.i_base_addr = ADDR_W'($urandom);
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (req_pending && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    if (req_pending) begin
      timeout_fail("done_wait");
      summary_and_finish();
    end
    @(negedge clk);
    check("in_ready_after_done", bus.o_in_ready, 1);
    check("busy_after_done", bus.o_busy, 0);
    check("done_single_cycle", bus.o_done, 0);
  endtask

  task automatic run_req(input int unsigned size, input bit rate,
                         input int base, input bit burst, input int nbeats);
    start_req(size, rate, base, burst, nbeats);
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  bus.o_in_ready, 0);
    check({tag, "_out_valid"}, bus.o_out_valid, 0);
    check({tag, "_mem_en"},    bus.o_mem_en, 0);
    check({tag, "_mem_addr"},  bus.o_mem_addr, 0);
    check({tag, "_busy"},      bus.o_busy, 0);
    check({tag, "_done"},      bus.o_done, 0);
    check({tag, "_blk_cnt"},   bus.o_blk_cnt, 0);
  endtask

  initial begin
    bus.i_in_valid  = 1'b0;
    bus.i_in_last   = 1'b0;
    bus.i_out_size  = '0;
    bus.i_rate_sel  = 1'b0;
    bus.i_base_addr = '0;
    bus.i_burst     = 1'b0;

    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;

    // Two SHAKE128 blocks, ready high
    rdy_mode = 0;
    run_req(2688, 1'b0, 0, 1'b0, 1);
    // Three-beat absorb, one SHAKE256 block
    run_req(1088, 1'b1, 5, 1'b0, 3);
    // Burst of eight blocks from base 4
    run_req(1344 * 8, 1'b0, 4, 1'b1, 1);
    // Address wrap
    run_req(1344 * 4, 1'b0, 126, 1'b1, 1);
    // Zero-size request
    run_req(0, 1'b1, 10, 1'b0, 2);
    // Partial final block boundaries
    run_req(2689, 1'b0, 20, 1'b0, 1);
    run_req(1, 1'b1, 30, 1'b1, 1);

    // Stall in SQUEEZE, then reset mid-request
    rdy_mode = 2;
    start_req(1344 * 3, 1'b0, 50, 1'b0, 1);
    begin
      int budget;
      budget = 0;
      while (!bus.o_out_valid && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.o_out_valid) begin
        timeout_fail("stall_valid_wait");
        summary_and_finish();
      end
    end
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", bus.o_out_valid, 1);
      check("stall_addr", bus.o_mem_addr, 50);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    req_pending = 1'b0;
    blk_open    = 1'b0;
    @(negedge clk);
    rdy_mode = 0;
    rst_n = 1'b1;
    run_req(1344 * 2, 1'b0, 7, 1'b0, 1);

    // Randomized requests
    for (int i = 0; i < 15; i++) begin
      rdy_mode = $urandom_range(0, 1);
      run_req($urandom_range(0, 1344 * 6), 1'($urandom_range(0, 1)),
              $urandom_range(0, ADDR_N - 1), 1'($urandom_range(0, 1)),
              $urandom_range(1, 3));
    end

    repeat (2) @(negedge clk);
    summary_and_finish();
  end

  initial begin
    #2000000;
    timeout_fail("global_watchdog");
    summary_and_finish();
  end

endmodule
`default_nettype wire
